// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared hex decoder, N common-cathode digits,
// double-buffered display word committed only at frame boundaries so a scan never tears.
module seg7_scan_ctrl #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_CYCLES = 1000,
  parameter int BLANK_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load_valid,
  input  logic [4*N_DIGITS-1:0] load_data,
  output logic                  load_ready,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [3:0]            digit_nib,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_tick
);

  localparam int TMAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = $clog2(N_DIGITS);

  localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         sel_idx;
  logic [TW-1:0]         tmr;
  logic [4*N_DIGITS-1:0] disp_reg;
  logic [4*N_DIGITS-1:0] pend_reg;
  logic                  pend_full;

  logic [3:0]            cur_nib;
  logic [N_DIGITS-1:0]   cur_sel;
  logic                  frame_end;
  logic                  boundary;

  always_comb begin
    cur_nib = '0;
    cur_sel = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib    = disp_reg[4*k +: 4];
        cur_sel[k] = 1'b1;
      end
    end
    frame_end = (state == BLANK) && (idx == IDX_LAST) && (tmr == BLANK_LAST);
    boundary  = frame_end || (state == IDLE);
  end

  // sel_idx tracks the digit actually on the pads, so the mask lines up with digit_sel
  always_comb begin
    seg_out = '0;
    if ((digit_sel != '0) && !blank_mask[sel_idx])
      seg_out = seg_in;
  end

  assign load_ready = ~pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      sel_idx    <= '0;
      tmr        <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_full  <= 1'b0;
      digit_nib  <= '0;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (boundary && pend_full) begin
        disp_reg  <= pend_reg;
        pend_full <= 1'b0;
      end else if (load_valid && !pend_full) begin
        pend_reg  <= load_data;
        pend_full <= 1'b1;
      end

      frame_tick <= frame_end;
      if (state == SHOW) begin
        digit_sel <= cur_sel;
        digit_nib <= cur_nib;
        sel_idx   <= idx;
      end else begin
        digit_sel <= '0;
      end

      if (!ena) begin
        state <= IDLE;
        idx   <= '0;
        tmr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= SHOW;
            idx   <= '0;
            tmr   <= '0;
          end
          SHOW: begin
            if (tmr == SHOW_LAST) begin
              state <= BLANK;
              tmr   <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          BLANK: begin
            if (tmr == BLANK_LAST) begin
              state <= SHOW;
              tmr   <= '0;
              idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position model checked every cycle plus directed scenarios
// (reset scan, idle load, no tearing, back-pressure, live mask, async reset).
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int R = 3;
  localparam int B = 1;
  localparam int F = N * (R + B);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  blank_mask = '0;
  logic        load_ready;
  logic [3:0]  digit_nib;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h3F; 4'h1: dec = 7'h06; 4'h2: dec = 7'h5B; 4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66; 4'h5: dec = 7'h6D; 4'h6: dec = 7'h7D; 4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F; 4'h9: dec = 7'h6F; 4'hA: dec = 7'h77; 4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39; 4'hD: dec = 7'h5E; 4'hE: dec = 7'h79; default: dec = 7'h71;
    endcase
  endfunction

  always_comb seg_in = dec(digit_nib);

  seg7_scan_ctrl #(
    .N_DIGITS(N),
    .REFRESH_CYCLES(R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .blank_mask(blank_mask),
    .digit_nib(digit_nib),
    .seg_in(seg_in),
    .seg_out(seg_out),
    .digit_sel(digit_sel),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: position within the frame decides what is lit; outputs lag position by one clock
  bit          m_on = 1'b0;
  int          m_p = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pfull = 1'b0;
  logic [3:0]  e_sel = '0;
  logic [3:0]  e_nib = '0;
  int          e_idx = 0;
  bit          e_tick = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on <= 1'b0; m_p <= 0; m_disp <= '0; m_pend <= '0; m_pfull <= 1'b0;
      e_sel <= '0; e_nib <= '0; e_idx <= 0; e_tick <= 1'b0;
    end else begin
      e_tick <= m_on && (m_p == F - 1);
      if (m_on && ((m_p % (R + B)) < R)) begin
        e_sel <= 4'(1 << (m_p / (R + B)));
        e_nib <= 4'(m_disp >> (4 * (m_p / (R + B))));
        e_idx <= m_p / (R + B);
      end else begin
        e_sel <= '0;
      end
      if ((!m_on || (m_p == F - 1)) && m_pfull) begin
        m_disp  <= m_pend;
        m_pfull <= 1'b0;
      end else if (load_valid && !m_pfull) begin
        m_pend  <= load_data;
        m_pfull <= 1'b1;
      end
      if (!ena) begin
        m_on <= 1'b0; m_p <= 0;
      end else if (!m_on) begin
        m_on <= 1'b1; m_p <= 0;
      end else begin
        m_p <= (m_p + 1) % F;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_sel", digit_sel, e_sel);
    chk("model_nib", digit_nib, e_nib);
    chk("model_tick", frame_tick, e_tick);
    chk("model_ready", load_ready, !m_pfull);
    chk("model_seg", seg_out, ((e_sel != 0) && !blank_mask[e_idx]) ? dec(e_nib) : 7'h00);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Entered just after the edge where digit d0 becomes lit; leaves at digit 0 of the next frame
  task automatic show_frame(input logic [15:0] w, input int d0);
    for (int d = d0; d < N; d++) begin
      @(negedge clk);
      chk("frame_sel", digit_sel, 32'(1 << d));
      chk("frame_nib", digit_nib, 32'((w >> (4 * d)) & 16'hF));
      repeat (4) cyc();
    end
  endtask

  int          exp_scan[16] = '{1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8, 0};
  logic [6:0]  lit4321[4]   = '{7'h06, 7'h5B, 7'h4F, 7'h66};
  int          n_wait;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", digit_sel, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_nib", digit_nib, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc();

    // Reset scan: 3 lit / 1 blank per digit, 16-clock period, decoder shows 0
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); @(negedge clk);
      chk("scan_sel", digit_sel, exp_scan[i]);
      chk("scan_seg", seg_out, (exp_scan[i] != 0) ? 7'h3F : 7'h00);
      chk("scan_tick", frame_tick, (i == 15) ? 1 : 0);
    end
    @(posedge clk); @(negedge clk);
    chk("scan_period", digit_sel, 1);

    // Load while idle: one-cycle ready dip, commit without waiting for a frame
    ena = 1'b0;
    cyc(); cyc();
    load_valid = 1'b1; load_data = 16'h4321;
    cyc();
    load_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready_low", load_ready, 0);
    cyc();
    @(negedge clk);
    chk("idle_ready_high", load_ready, 1);
    cyc();
    ena = 1'b1;
    cyc(); cyc();
    for (int d = 0; d < N; d++) begin
      @(negedge clk);
      chk("idle_nib", digit_nib, d + 1);
      chk("idle_seg", seg_out, lit4321[d]);
      repeat (4) cyc();
    end

    // No tearing: load during digit 1, old word finishes the frame
    repeat (4) cyc();
    load_valid = 1'b1; load_data = 16'hABCD;
    cyc();
    load_valid = 1'b0;
    repeat (3) cyc();
    show_frame(16'h4321, 2);
    show_frame(16'hABCD, 0);

    // Back-pressure: second word waits for the commit of the first
    load_valid = 1'b1; load_data = 16'h1111;
    cyc();
    load_data = 16'h2222;
    n_wait = 0;
    @(negedge clk);
    while (!load_ready && n_wait < 40) begin
      cyc();
      n_wait++;
      @(negedge clk);
    end
    chk("bp_stall_cycles", n_wait, 14);
    cyc();
    load_valid = 1'b0;
    show_frame(16'h1111, 0);
    show_frame(16'h2222, 0);

    // Live mask in the middle of digit 2
    repeat (9) cyc();
    blank_mask = 4'b0100;
    @(negedge clk);
    chk("mask_seg", seg_out, 0);
    chk("mask_sel", digit_sel, 4'b0100);
    repeat (3) cyc();
    @(negedge clk);
    chk("mask_other_sel", digit_sel, 4'b1000);
    chk("mask_other_seg", seg_out, 7'h5B);
    blank_mask = 4'b0000;

    // Asynchronous reset mid-SHOW with a word pending
    repeat (4) cyc();
    load_valid = 1'b1; load_data = 16'h9999;
    cyc();
    load_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", seg_out, 0);
    chk("arst_sel", digit_sel, 0);
    chk("arst_nib", digit_nib, 0);
    chk("arst_ready", load_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc(); cyc();
    show_frame(16'h0000, 0);
    @(negedge clk);
    chk("arst_after_ready", load_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
